// File: rtl/m_fft_pkg.sv
// Shared constants and types for the 8-point FFT result unloader.
package m_fft_pkg;

  localparam int N_POINTS = 8;
  localparam int ADDR_W   = 3;
  localparam int DW_DEF   = 32;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_e;

  function automatic logic [ADDR_W-1:0] bitrev3(input logic [ADDR_W-1:0] a);
    return {a[0], a[1], a[2]};
  endfunction

endpackage

// File: rtl/m_fft_unload.sv
// Captures one parallel 8-point complex frame and streams it out one point
// per beat, in natural or bit-reversed index order, under valid/ready.
module m_fft_unload
  import m_fft_pkg::*;
#(
  parameter int DW      = DW_DEF,
  parameter int BIT_REV = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DW-1:0]     data00r,
  input  logic [DW-1:0]     data01r,
  input  logic [DW-1:0]     data02r,
  input  logic [DW-1:0]     data03r,
  input  logic [DW-1:0]     data04r,
  input  logic [DW-1:0]     data05r,
  input  logic [DW-1:0]     data06r,
  input  logic [DW-1:0]     data07r,
  input  logic [DW-1:0]     data00i,
  input  logic [DW-1:0]     data01i,
  input  logic [DW-1:0]     data02i,
  input  logic [DW-1:0]     data03i,
  input  logic [DW-1:0]     data04i,
  input  logic [DW-1:0]     data05i,
  input  logic [DW-1:0]     data06i,
  input  logic [DW-1:0]     data07i,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [2*DW-1:0]   out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              frame_done
);

  state_e                             state_q, state_d;
  logic [ADDR_W-1:0]                  count_q, count_d;
  logic [N_POINTS-1:0][2*DW-1:0]      buf_q, buf_d;
  logic                               frame_done_q, frame_done_d;
  logic [N_POINTS-1:0][2*DW-1:0]      frame_in;

  // Entry k holds {real, imag} of point k.
  assign frame_in = {{data07r, data07i}, {data06r, data06i},
                     {data05r, data05i}, {data04r, data04i},
                     {data03r, data03i}, {data02r, data02i},
                     {data01r, data01i}, {data00r, data00i}};

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    buf_d        = buf_q;
    frame_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          buf_d   = frame_in;
          count_d = '0;
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (out_ready) begin
          // Counter wraps to 0 naturally after beat 7.
          count_d = count_q + 3'd1;
          if (count_q == 3'd7) begin
            state_d      = IDLE;
            frame_done_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      count_q      <= '0;
      buf_q        <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      buf_q        <= buf_d;
      frame_done_q <= frame_done_d;
    end
  end

  // All outputs are decoded from state only, so ready never loops back to valid.
  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == STREAM);
  assign out_last   = (state_q == STREAM) && (count_q == 3'd7);
  assign out_addr   = (BIT_REV != 0) ? bitrev3(count_q) : count_q;
  assign out_data   = buf_q[out_addr];
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_m_fft_unload.sv
// Bench for m_fft_unload: bit-reversed and natural-order instances share stimulus;
// expected beats are queued at capture and checked at each transfer.
module tb_m_fft_unload;
  localparam int DW = 32;

  typedef struct packed {
    logic [2:0]      addr;
    logic [2*DW-1:0] data;
    logic            last;
  } beat_t;

  localparam logic [2:0] ORD [8] = '{3'd0, 3'd4, 3'd2, 3'd6, 3'd1, 3'd5, 3'd3, 3'd7};

  logic          clk, rst, in_valid, out_ready;
  logic [DW-1:0] dr [8];
  logic [DW-1:0] di [8];

  logic          in_ready_b, out_valid_b, out_last_b, frame_done_b;
  logic [2:0]    out_addr_b;
  logic [2*DW-1:0] out_data_b;
  logic          in_ready_n, out_valid_n, out_last_n, frame_done_n;
  logic [2:0]    out_addr_n;
  logic [2*DW-1:0] out_data_n;
  beat_t         ob_b, ob_n;

  beat_t q_b[$];
  beat_t q_n[$];
  int n_vec = 0;
  int n_err = 0;

  assign ob_b = {out_addr_b, out_data_b, out_last_b};
  assign ob_n = {out_addr_n, out_data_n, out_last_n};

  m_fft_unload #(.DW(DW), .BIT_REV(1)) u_br (
    .clk(clk), .rst(rst),
    .data00r(dr[0]), .data01r(dr[1]), .data02r(dr[2]), .data03r(dr[3]),
    .data04r(dr[4]), .data05r(dr[5]), .data06r(dr[6]), .data07r(dr[7]),
    .data00i(di[0]), .data01i(di[1]), .data02i(di[2]), .data03i(di[3]),
    .data04i(di[4]), .data05i(di[5]), .data06i(di[6]), .data07i(di[7]),
    .in_valid(in_valid), .in_ready(in_ready_b), .out_addr(out_addr_b),
    .out_data(out_data_b), .out_valid(out_valid_b), .out_ready(out_ready),
    .out_last(out_last_b), .frame_done(frame_done_b));

  m_fft_unload #(.DW(DW), .BIT_REV(0)) u_nat (
    .clk(clk), .rst(rst),
    .data00r(dr[0]), .data01r(dr[1]), .data02r(dr[2]), .data03r(dr[3]),
    .data04r(dr[4]), .data05r(dr[5]), .data06r(dr[6]), .data07r(dr[7]),
    .data00i(di[0]), .data01i(di[1]), .data02i(di[2]), .data03i(di[3]),
    .data04i(di[4]), .data05i(di[5]), .data06i(di[6]), .data07i(di[7]),
    .in_valid(in_valid), .in_ready(in_ready_n), .out_addr(out_addr_n),
    .out_data(out_data_n), .out_valid(out_valid_n), .out_ready(out_ready),
    .out_last(out_last_n), .frame_done(frame_done_n));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_frame(input logic [DW-1:0] base);
    for (int k = 0; k < 8; k++) begin
      dr[k] = base + DW'(k) + 1;
      di[k] = base + DW'(k) + 'h100;
    end
  endtask

  task automatic push_frame();
    for (int b = 0; b < 8; b++) begin
      q_b.push_back('{addr: ORD[b], data: {dr[ORD[b]], di[ORD[b]]}, last: (b == 7)});
      q_n.push_back('{addr: 3'(b), data: {dr[b], di[b]}, last: (b == 7)});
    end
  endtask

  // Presents a frame on one edge with the DUT expected idle.
  task automatic capture(input logic [DW-1:0] base);
    @(negedge clk);
    set_frame(base);
    in_valid = 1'b1;
    push_frame();
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic test_reset();
    n_vec++;
    if ({in_ready_b, out_valid_b, out_last_b, frame_done_b, out_addr_b, out_data_b} !==
        {1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 64'd0}) begin
      n_err++;
      $display("FAIL reset.br rdy=%b vld=%b last=%b done=%b addr=%0d data=%h, want 1 0 0 0 0 0",
               in_ready_b, out_valid_b, out_last_b, frame_done_b, out_addr_b, out_data_b);
    end
    n_vec++;
    if ({in_ready_n, out_valid_n, out_last_n, frame_done_n, out_addr_n, out_data_n} !==
        {1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 64'd0}) begin
      n_err++;
      $display("FAIL reset.nat rdy=%b vld=%b last=%b done=%b addr=%0d data=%h, want 1 0 0 0 0 0",
               in_ready_n, out_valid_n, out_last_n, frame_done_n, out_addr_n, out_data_n);
    end
  endtask

  task automatic test_frame();
    beat_t eb, en;
    int beats = 0, last_beat = -1, done_at = -1, pulses = 0;
    out_ready = 1'b1;
    capture(32'h0);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 1) begin
        n_vec++;
        if (out_valid_b !== 1'b1 || out_valid_n !== 1'b1) begin
          n_err++;
          $display("FAIL frame.latency out_valid br=%b nat=%b, want 1", out_valid_b, out_valid_n);
        end
      end
      if (frame_done_b && frame_done_n) begin pulses++; done_at = c; end
      if (out_valid_b && out_ready) begin
        n_vec++; beats++; last_beat = c;
        if (q_b.size() == 0 || q_n.size() == 0) begin
          n_err++; $display("FAIL frame.beat unexpected beat addr=%0d", out_addr_b);
        end else begin
          eb = q_b.pop_front(); en = q_n.pop_front();
          if (ob_b !== eb || ob_n !== en) begin
            n_err++;
            $display("FAIL frame.beat br=%h want %h nat=%h want %h", ob_b, eb, ob_n, en);
          end
        end
      end
    end
    n_vec++;
    if (beats != 8 || last_beat != 8 || done_at != 9 || pulses != 1) begin
      n_err++;
      $display("FAIL frame.timing beats=%0d last_at=%0d done_at=%0d pulses=%0d, want 8 8 9 1",
               beats, last_beat, done_at, pulses);
    end
  endtask

  task automatic test_random_ready();
    beat_t eb, en, pb, pn;
    int beats = 0;
    logic stalled = 1'b0;
    capture(32'h1000);
    for (int c = 0; c < 100 && beats < 8; c++) begin
      @(negedge clk);
      if (stalled) begin
        n_vec++;
        if (ob_b !== pb || ob_n !== pn || out_valid_b !== 1'b1) begin
          n_err++;
          $display("FAIL random.stall br=%h was %h nat=%h was %h vld=%b", ob_b, pb, ob_n, pn, out_valid_b);
        end
      end
      out_ready = 1'($urandom_range(0, 1));
      if (out_valid_b && out_ready) begin
        n_vec++; beats++;
        if (q_b.size() == 0 || q_n.size() == 0) begin
          n_err++; $display("FAIL random.beat unexpected beat addr=%0d", out_addr_b);
        end else begin
          eb = q_b.pop_front(); en = q_n.pop_front();
          if (ob_b !== eb || ob_n !== en) begin
            n_err++;
            $display("FAIL random.beat br=%h want %h nat=%h want %h", ob_b, eb, ob_n, en);
          end
        end
      end
      stalled = out_valid_b && !out_ready;
      pb = ob_b; pn = ob_n;
    end
    @(negedge clk);
    out_ready = 1'b0;
    n_vec++;
    if (beats != 8 || q_b.size() != 0 || out_valid_b !== 1'b0) begin
      n_err++;
      $display("FAIL random.count beats=%0d left=%0d vld=%b, want 8 0 0", beats, q_b.size(), out_valid_b);
    end
  endtask

  task automatic test_back_to_back();
    beat_t eb, en;
    int caps = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 37; c++) begin
      @(negedge clk);
      set_frame(DW'(c) << 16);
      in_valid = (c < 28);
      n_vec++;
      if (in_ready_b !== (c % 9 == 0) || in_ready_n !== (c % 9 == 0)) begin
        n_err++;
        $display("FAIL b2b.ready cyc=%0d br=%b nat=%b, want %b", c, in_ready_b, in_ready_n, c % 9 == 0);
      end
      if (in_valid && c % 9 == 0) begin push_frame(); caps++; end
      if (out_valid_b && out_ready) begin
        n_vec++;
        if (q_b.size() == 0 || q_n.size() == 0) begin
          n_err++; $display("FAIL b2b.beat unexpected beat cyc=%0d", c);
        end else begin
          eb = q_b.pop_front(); en = q_n.pop_front();
          if (ob_b !== eb || ob_n !== en) begin
            n_err++;
            $display("FAIL b2b.beat cyc=%0d br=%h want %h nat=%h want %h", c, ob_b, eb, ob_n, en);
          end
        end
      end
    end
    in_valid = 1'b0;
    n_vec++;
    if (caps != 4 || q_b.size() != 0 || q_n.size() != 0) begin
      n_err++;
      $display("FAIL b2b.drain caps=%0d left=%0d/%0d, want 4 0 0", caps, q_b.size(), q_n.size());
    end
  endtask

  task automatic test_mid_reset();
    beat_t eb, en;
    int beats = 0;
    out_ready = 1'b1;
    capture(32'h2000);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_vec++; beats++;
      eb = q_b.pop_front(); en = q_n.pop_front();
      if (ob_b !== eb || ob_n !== en || out_valid_b !== 1'b1) begin
        n_err++;
        $display("FAIL mreset.pre br=%h want %h nat=%h want %h", ob_b, eb, ob_n, en);
      end
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_vec++;
    if ({out_valid_b, out_valid_n, in_ready_b, out_last_b, frame_done_b, out_addr_b, out_data_b} !==
        {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 64'd0}) begin
      n_err++;
      $display("FAIL mreset.async vld=%b/%b rdy=%b last=%b done=%b addr=%0d data=%h, want 0 0 1 0 0 0 0",
               out_valid_b, out_valid_n, in_ready_b, out_last_b, frame_done_b, out_addr_b, out_data_b);
    end
    q_b.delete(); q_n.delete();
    @(negedge clk);
    rst = 1'b0;
    set_frame(32'h3000);
    in_valid = 1'b1;
    push_frame();
    @(posedge clk);
    #1 in_valid = 1'b0;
    beats = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      n_vec++;
      if (q_b.size() == 0 || q_n.size() == 0) begin
        n_err++; $display("FAIL mreset.post queue empty at beat %0d", c);
      end else begin
        eb = q_b.pop_front(); en = q_n.pop_front();
        if (ob_b !== eb || ob_n !== en || out_valid_b !== 1'b1) begin
          n_err++;
          $display("FAIL mreset.post beat=%0d br=%h want %h nat=%h want %h vld=%b",
                   c, ob_b, eb, ob_n, en, out_valid_b);
        end
      end
    end
  endtask

  task automatic test_last_stall();
    beat_t eb, en;
    int stall = 0;
    logic seen_done;
    @(negedge clk);
    out_ready = 1'b1;
    capture(32'h4000);
    for (int c = 0; c < 40 && q_b.size() != 0; c++) begin
      @(negedge clk);
      out_ready = !(out_last_b && stall < 20);
      if (!out_ready) begin
        stall++;
        n_vec++;
        if (ob_b !== q_b[0] || ob_n !== q_n[0] || out_valid_b !== 1'b1 ||
            frame_done_b !== 1'b0 || frame_done_n !== 1'b0) begin
          n_err++;
          $display("FAIL stall.last stall=%0d br=%h want %h vld=%b done=%b, want done 0",
                   stall, ob_b, q_b[0], out_valid_b, frame_done_b);
        end
      end else if (out_valid_b) begin
        n_vec++;
        eb = q_b.pop_front(); en = q_n.pop_front();
        if (ob_b !== eb || ob_n !== en) begin
          n_err++;
          $display("FAIL stall.beat br=%h want %h nat=%h want %h", ob_b, eb, ob_n, en);
        end
      end
    end
    @(negedge clk);
    seen_done = frame_done_b && frame_done_n;
    n_vec++;
    if (stall != 20 || !seen_done || out_valid_b !== 1'b0) begin
      n_err++;
      $display("FAIL stall.done stalls=%0d done=%b vld=%b, want 20 1 0", stall, seen_done, out_valid_b);
    end
    @(negedge clk);
    n_vec++;
    if (frame_done_b !== 1'b0 || frame_done_n !== 1'b0) begin
      n_err++;
      $display("FAIL stall.pulse done=%b/%b second cycle, want 0", frame_done_b, frame_done_n);
    end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    set_frame(32'h0);
    #1;
    test_reset();
    @(negedge clk);
    test_reset();
    rst = 1'b0;
    test_frame();
    test_random_ready();
    test_back_to_back();
    test_mid_reset();
    test_last_stall();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
